console_uart_bridge: RTL

Synthesizable console peripheral on the core's data memory interface, downstream of the phoeniX data port. It replaces the simulation-only printf hook on real hardware. Byte writes to the console address go into a FIFO and are serialized as 8N1 UART frames on `uart_tx`. All other bus traffic is ignored; the block never drives the data bus.

---
 rtl/console_uart_bridge_pkg.sv | 32 +++
 rtl/console_fifo.sv | 65 ++++++
 rtl/console_uart_bridge.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/console_uart_bridge_pkg.sv
// Shared definitions for the console UART bridge: bus encodings, the default
// console address and the transmitter state encoding.
package console_uart_bridge_pkg;

    localparam logic READ    = 1'b0;
    localparam logic WRITE   = 1'b1;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [31:0] CONSOLE_ADDRESS_DEFAULT = 32'h1000_0000;
    localparam int          UART_DATA_BITS          = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Only byte lane 3 (data[7:0]) carries console characters.
    function automatic logic is_console_push(
        input logic        enable,
        input logic        state,
        input logic [31:0] address,
        input logic        lane_byte0,
        input logic [31:0] console_address
    );
        return (enable == ENABLE) && (state == WRITE) &&
               (address == console_address) && lane_byte0;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO with (log2(DEPTH)+1)-bit wrapping pointers; full/empty come
// from comparing the pointer MSBs and the remaining index bits.
module console_fifo
    import console_uart_bridge_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Fullness and emptiness are judged on registered pointers, so a push
    // into a full FIFO is refused even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/console_uart_bridge.sv
// Console peripheral: captures byte writes to the console address into a FIFO
// and serializes them as 8N1 UART frames on uart_tx. Never drives the bus.
module console_uart_bridge
    import console_uart_bridge_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDRESS = CONSOLE_ADDRESS_DEFAULT,
    parameter int          CLOCK_DIVIDER   = 16,
    parameter int          FIFO_DEPTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_data,
    output logic        uart_tx,
    output logic        console_busy,
    output logic        fifo_full,
    output logic [15:0] dropped_count
);

    localparam int DIV_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    tx_state_e        state_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic [15:0]      dropped_q, dropped_d;

    logic       push_req;
    logic       fifo_pop;
    logic       fifo_empty;
    logic       fifo_full_w;
    logic [7:0] fifo_rdata;
    logic       div_last;
    logic       unused_bus_bits;

    assign unused_bus_bits = ^{data_memory_interface_data[31:8],
                               data_memory_interface_frame_mask[2:0]};

    assign push_req = is_console_push(data_memory_interface_enable,
                                      data_memory_interface_state,
                                      data_memory_interface_address,
                                      data_memory_interface_frame_mask[3],
                                      CONSOLE_ADDRESS);

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push_req),
        .pop_i   (fifo_pop),
        .data_i  (data_memory_interface_data[7:0]),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full_w),
        .empty_o (fifo_empty)
    );

    assign div_last = (div_q == DIV_LAST);

    // Pop from IDLE, or on the last STOP cycle so frames run back to back.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == TX_IDLE) || ((state_q == TX_STOP) && div_last));

    always_comb begin
        dropped_d = dropped_q;
        if (push_req && fifo_full_w && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    // tx_q is loaded with the level of the state being entered, so the line
    // changes exactly on the state-change edge and never glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q <= fifo_rdata;
                        div_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (div_last) begin
                        div_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= TX_DATA;
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                TX_DATA: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                TX_STOP: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (!fifo_empty) begin
                            shift_q <= fifo_rdata;
                            tx_q    <= 1'b0;
                            state_q <= TX_START;
                        end else begin
                            state_q <= TX_IDLE;
                        end
                    end else begin
                        div_q <= div_q + DIV_ONE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign uart_tx       = tx_q;
    assign console_busy  = !fifo_empty || (state_q != TX_IDLE);
    assign fifo_full     = fifo_full_w;
    assign dropped_count = dropped_q;

endmodule
